score_render_ctrl: RTL and testbench

- Sequences the score digit renderer: captures a score, loads it, runs the bit-serial render, and converts each emitted glyph bit into an (x, y, colour) plot request for the shared VGA plot port.
- Back-pressures the renderer via its pause input when the plot port stalls.
- Sits between the game FSM (start/done handshake) and the VGA adapter.

---
 rtl/score_render_ctrl_if.sv | 31 +++
 rtl/score_render_ctrl.sv | 129 ++++++++++++
 tb/tb_score_render_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_render_ctrl_if.sv
// rtl/score_render_ctrl_if.sv - renderer control and VGA plot bundle for score_render_ctrl
// master = controller side, slave = renderer/plot-port side.
interface score_render_ctrl_if;
  logic       rd_resetn;
  logic       rd_ld_en;
  logic       rd_draw_en;
  logic       rd_pause;
  logic       rd_done;
  logic       rd_cur_bit;
  logic [5:0] rd_offset;
  logic [1:0] rd_digit_offset;
  logic       plot;
  logic       plot_ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  modport master (
    output rd_resetn, rd_ld_en, rd_draw_en, rd_pause,
    input  rd_done, rd_cur_bit, rd_offset, rd_digit_offset,
    output plot, x, y, colour,
    input  plot_ready
  );

  modport slave (
    input  rd_resetn, rd_ld_en, rd_draw_en, rd_pause,
    output rd_done, rd_cur_bit, rd_offset, rd_digit_offset,
    input  plot, x, y, colour,
    output plot_ready
  );
endinterface

// File: rtl/score_render_ctrl.sv
// rtl/score_render_ctrl.sv - sequences the bit-serial score renderer into VGA plot requests
// SCORE_BG_CLEAR_EN: plot every glyph bit (0-bits in BG_COLOUR) instead of only 1-bits.
module score_render_ctrl #(
  parameter logic [7:0] X0        = 8'd8,
  parameter logic [6:0] Y0        = 7'd8,
  parameter logic [7:0] SPACING   = 8'd9,
  parameter logic [2:0] FG_COLOUR = 3'b111
`ifdef SCORE_BG_CLEAR_EN
  , parameter logic [2:0] BG_COLOUR = 3'b000
`endif
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [9:0]                 score,
  output logic                       busy,
  output logic                       done,
  score_render_ctrl_if.master        rd
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, FINISH} state_t;

  state_t     state_q, state_d;
  logic [9:0] sc_q, sc_d;
  logic [5:0] tag_off_q, tag_off_d;
  logic [1:0] tag_dig_q, tag_dig_d;
  logic       tag_v_q, tag_v_d;

  logic [1:0] ndig;
  logic       want;
  logic       advance;
  logic       emit;
  logic       consumed;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q   <= IDLE;
      sc_q      <= 10'd0;
      tag_off_q <= 6'd0;
      tag_dig_q <= 2'd0;
      tag_v_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sc_q      <= sc_d;
      tag_off_q <= tag_off_d;
      tag_dig_q <= tag_dig_d;
      tag_v_q   <= tag_v_d;
    end
  end

  always_comb begin
    if (sc_q > 10'd99) begin
      ndig = 2'd2;
    end else if (sc_q > 10'd9) begin
      ndig = 2'd1;
    end else begin
      ndig = 2'd0;
    end
  end

  always_comb begin
    state_d       = state_q;
    sc_d          = sc_q;
    busy          = 1'b0;
    done          = 1'b0;
    rd.rd_resetn  = 1'b1;
    rd.rd_ld_en   = 1'b0;
    rd.rd_draw_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        rd.rd_resetn = 1'b0;
        if (start) begin
          sc_d    = (score > 10'd999) ? 10'd999 : score;
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy        = 1'b1;
        rd.rd_ld_en = 1'b1;
        state_d     = DRAW;
      end
      DRAW: begin
        busy          = 1'b1;
        rd.rd_draw_en = 1'b1;
        // Wait for the last tagged bit to drain before reporting completion.
        if (rd.rd_done && !tag_v_q) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef SCORE_BG_CLEAR_EN
    want      = tag_v_q;
    rd.colour = rd.rd_cur_bit ? FG_COLOUR : BG_COLOUR;
`else
    want      = tag_v_q & rd.rd_cur_bit;
    rd.colour = FG_COLOUR;
`endif
    rd.rd_pause = want & ~rd.plot_ready;
    advance     = rd.rd_draw_en & ~rd.rd_pause;
    // Positions past the last real digit are renderer overrun, never plotted.
    emit        = advance & ~((rd.rd_offset == 6'd0) && (rd.rd_digit_offset > ndig));
    consumed    = tag_v_q & (~want | rd.plot_ready);

    tag_off_d = tag_off_q;
    tag_dig_d = tag_dig_q;
    tag_v_d   = tag_v_q;
    if (emit) begin
      tag_off_d = rd.rd_offset;
      tag_dig_d = rd.rd_digit_offset;
      tag_v_d   = 1'b1;
    end else if (consumed) begin
      tag_v_d   = 1'b0;
    end

    rd.plot = want;
    rd.x    = X0 + ({6'd0, tag_dig_q} * SPACING) + {5'd0, 3'd7 - tag_off_q[2:0]};
    rd.y    = Y0 + {4'd0, tag_off_q[5:3]};
  end

endmodule

// File: tb/tb_score_render_ctrl.sv
// tb/tb_score_render_ctrl.sv - scoreboard bench for score_render_ctrl with a behavioural renderer
// SCORE_BG_CLEAR_EN switches the expected plot stream to every-bit mode.
module tb_score_render_ctrl;
  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [9:0] score;
  logic       busy;
  logic       done;
  int         cyc = 0;

  score_render_ctrl_if rif ();

  score_render_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .score  (score),
    .busy   (busy),
    .done   (done),
    .rd     (rif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] font(input int d);
    case (d)
      0: return 64'h003C_6666_6666_3C3D;
      1: return 64'h007E_1818_1818_1C19;
      2: return 64'h007E_0C18_3060_663D;
      3: return 64'h003C_6660_3860_663D;
      4: return 64'h0030_307E_3634_3831;
      5: return 64'h003C_6660_3E06_067F;
      6: return 64'h003C_6666_3E06_0C39;
      7: return 64'h2030_3018_0C06_037F;
      8: return 64'h003C_6666_3C66_663D;
      default: return 64'h001C_3060_7C66_663D;
    endcase
  endfunction

  function automatic int ndig_of(input int s);
    if (s > 99) return 3;
    if (s > 9) return 2;
    return 1;
  endfunction

  function automatic int digit_of(input int s, input int d);
    int p;
    p = ndig_of(s) - 1 - d;
    if (p == 2) return s / 100;
    if (p == 1) return (s / 10) % 10;
    if (p == 0) return s % 10;
    return 0;
  endfunction

  function automatic logic glyph_bit(input int d, input int off);
    logic [63:0] g;
    g = font(d);
    return g[off];
  endfunction

  // Behavioural renderer: cur_bit is registered, so it lags offset by one cycle.
  int         rd_score = 0;
  int         r_sc = 0;
  logic [5:0] r_off;
  logic [1:0] r_dig;
  logic [1:0] r_last;
  logic       r_cur;
  logic       r_done;

  always @(posedge clk) begin
    if (!rif.rd_resetn) begin
      r_off  <= 6'd0;
      r_dig  <= 2'd0;
      r_cur  <= 1'b0;
      r_done <= 1'b0;
    end else if (rif.rd_ld_en) begin
      r_sc   <= rd_score;
      r_last <= 2'(ndig_of(rd_score) - 1);
    end else if (rif.rd_draw_en && !rif.rd_pause && !r_done) begin
      r_cur <= glyph_bit(digit_of(r_sc, int'(r_dig)), int'(r_off));
      if (r_off == 6'd63) begin
        r_off <= 6'd0;
        r_dig <= r_dig + 2'd1;
        if (r_dig == r_last) r_done <= 1'b1;
      end else begin
        r_off <= r_off + 6'd1;
      end
    end
  end

  assign rif.rd_offset       = r_off;
  assign rif.rd_digit_offset = r_dig;
  assign rif.rd_cur_bit      = r_cur;
  assign rif.rd_done         = r_done;

  logic [17:0] exp_q[$];
  int   c0 = 0;
  int   mrel;
  int   n_plot, n_fg, n_done, done_rel, busy_first, busy_last, n_pause, ld_rel, first_rel;
  bit   mon_en = 1'b0;
  bit   prev_pause = 1'b0;
  logic [17:0] pix, prev_pix;

  always @(negedge clk) begin
    if (mon_en) begin
      mrel = cyc - c0;
      pix  = {rif.x, rif.y, rif.colour};
      if (rif.plot && first_rel < 0) first_rel = mrel;
      if (rif.plot && rif.plot_ready) begin
        n_plot++;
        if (rif.colour == 3'b111) n_fg++;
        if (exp_q.size() == 0) chk("extra_plot", 1, 0);
        else chk("pixel", int'(pix), int'(exp_q.pop_front()));
      end
      if (rif.rd_pause) begin
        n_pause++;
        if (prev_pause) chk("stall_hold", int'(pix), int'(prev_pix));
      end
      prev_pause = rif.rd_pause;
      prev_pix   = pix;
      if (done) begin
        n_done++;
        done_rel = mrel;
      end
      if (busy) begin
        if (busy_first < 0) busy_first = mrel;
        busy_last = mrel;
      end
      if (rif.rd_ld_en) ld_rel = mrel;
    end
  end

  task automatic push_expected(input int s);
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    logic       b;
    exp_q.delete();
    for (int d = 0; d < ndig_of(s); d++) begin
      for (int off = 0; off < 64; off++) begin
        b  = glyph_bit(digit_of(s, d), off);
        ex = 8'(8 + d * 9 + 7 - (off % 8));
        ey = 7'(8 + off / 8);
        ec = b ? 3'b111 : 3'b000;
`ifdef SCORE_BG_CLEAR_EN
        exp_q.push_back({ex, ey, ec});
`else
        if (b) exp_q.push_back({ex, ey, ec});
`endif
      end
    end
  endtask

  task automatic run_score(input int sc, input bit stall, input bit dbl_start,
                           input int exp_done, input int exp_plots, input string nm);
    int s;
    int n_exp;
    int waited;
    s = (sc > 999) ? 999 : sc;
    push_expected(s);
    n_exp      = exp_q.size();
    n_plot     = 0;
    n_fg       = 0;
    n_done     = 0;
    done_rel   = -1;
    busy_first = -1;
    busy_last  = -1;
    n_pause    = 0;
    ld_rel     = -1;
    first_rel  = -1;
    prev_pause = 1'b0;
    rd_score   = s;
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b1;
    score = 10'(sc);
    rif.plot_ready = 1'b1;
    mon_en = 1'b1;
    waited = 0;
    while (n_done == 0 && waited < 400) begin
      @(posedge clk); #1;
      waited++;
      start = 1'b0;
      if (dbl_start && (cyc - c0) == 10) begin
        start = 1'b1;
        score = 10'd5;
      end
      rif.plot_ready = !(stall && (cyc - c0) >= 3 && (cyc - c0) < 8);
    end
    if (waited >= 400) chk({nm, "_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk({nm, "_done_cyc"}, done_rel, exp_done);
    chk({nm, "_done_cnt"}, n_done, 1);
    chk({nm, "_plots_model"}, n_plot, n_exp);
    chk({nm, "_plots"}, n_plot, exp_plots);
    chk({nm, "_left"}, exp_q.size(), 0);
    chk({nm, "_busy_first"}, busy_first, 1);
    chk({nm, "_busy_last"}, busy_last, exp_done);
    chk({nm, "_ld_cyc"}, ld_rel, 1);
    chk({nm, "_first_pix"}, first_rel, 3);
    chk({nm, "_pauses"}, n_pause, stall ? 5 : 0);
  endtask

  int waited_r;

  initial begin
    resetn = 1'b1;
    start  = 1'b0;
    score  = 10'd0;
    rif.plot_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_plot", rif.plot, 0);
    chk("rst_rd_resetn", rif.rd_resetn, 0);
    chk("rst_ld", rif.rd_ld_en, 0);
    chk("rst_draw", rif.rd_draw_en, 0);
    chk("rst_pause", rif.rd_pause, 0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);

`ifdef SCORE_BG_CLEAR_EN
    run_score(7, 1'b0, 1'b0, 68, 64, "s7");
    chk("s7_fg", n_fg, 20);
    chk("s7_bg", n_plot - n_fg, 44);
    run_score(123, 1'b0, 1'b1, 196, 192, "s123");
    run_score(0, 1'b0, 1'b0, 68, 64, "s0");
`else
    run_score(7, 1'b0, 1'b0, 68, 20, "s7");
    run_score(7, 1'b1, 1'b0, 73, 20, "s7_stall");
    push_expected(123);
    run_score(123, 1'b0, 1'b1, 196, exp_q.size(), "s123");
    push_expected(999);
    run_score(999, 1'b0, 1'b0, 196, exp_q.size(), "s999");
    push_expected(999);
    run_score(1023, 1'b0, 1'b0, 196, exp_q.size(), "s1023");
    push_expected(45);
    run_score(45, 1'b0, 1'b0, 132, exp_q.size(), "s45");
    push_expected(0);
    run_score(0, 1'b0, 1'b0, 68, exp_q.size(), "s0");
`endif

    exp_q.delete();
    rd_score = 123;
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b1;
    score = 10'd123;
    rif.plot_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited_r = 0;
    while (!(rif.plot && (cyc - c0) >= 20) && waited_r < 200) begin
      @(posedge clk); #1;
      waited_r++;
    end
    chk("mid_plot_before", rif.plot, 1);
    resetn = 1'b1;
    #1;
    chk("mid_plot_drop", rif.plot, 0);
    chk("mid_rd_resetn", rif.rd_resetn, 0);
    chk("mid_busy", busy, 0);
    chk("mid_draw", rif.rd_draw_en, 0);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("idle_rd_resetn", rif.rd_resetn, 0);
    chk("idle_plot", rif.plot, 0);
`ifdef SCORE_BG_CLEAR_EN
    run_score(5, 1'b0, 1'b0, 68, 64, "s5_after_rst");
`else
    push_expected(5);
    run_score(5, 1'b0, 1'b0, 68, exp_q.size(), "s5_after_rst");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
